// File: rtl/req_encoder8_if.sv
// ---------------------------------------------------------------------------
// req_encoder8_if
// Purpose : Bundles the request/grant signals of the edge-triggered
//           8-input priority encoder req_encoder8.
// Signals :
//   req_n [7:0] request lines, active-low, bit i = source i
//   ei_n        enable-in, active-low; high blocks new grants
//   ack         consumer accepts the presented code (only while valid=1)
//   code  [2:0] binary index of the granted request
//   valid       code is stable and awaiting ack
//   gs_n        group-select, active-low (enabled and something pending)
//   eo_n        enable-out, active-low (enabled and nothing pending)
//   ovf         sticky overflow: edge arrived on an already-pending bit
// Modports: master = request source / consumer side, slave = encoder.
// ---------------------------------------------------------------------------
interface req_encoder8_if;
  logic [7:0] req_n;
  logic       ei_n;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic       gs_n;
  logic       eo_n;
  logic       ovf;

  modport master (
    output req_n, ei_n, ack,
    input  code, valid, gs_n, eo_n, ovf
  );

  modport slave (
    input  req_n, ei_n, ack,
    output code, valid, gs_n, eo_n, ovf
  );
endinterface

// File: rtl/req_encoder8.sv
// ---------------------------------------------------------------------------
// req_encoder8
// Purpose : Edge-triggered 8-input priority encoder with a grant/ack
//           handshake. Falling edges on req_n latch into a pending vector;
//           a two-state FSM (IDLE/GRANT) presents the winning index on
//           code with valid=1 and holds it until ack.
// Ports   :
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  req_encoder8_if.slave (req_n, ei_n, ack in; code, valid, gs_n,
//        eo_n, ovf out)
// Config  : define RR_PRIORITY_EN for rotating priority (search starts one
//           below the last served index); default is fixed priority with
//           index 7 highest.
// ---------------------------------------------------------------------------
module req_encoder8 (
  input logic           clk,
  input logic           rst,
  req_encoder8_if.slave bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_req_q;
  logic [7:0] r_block;
  logic [7:0] r_pending;
  logic [2:0] r_code;
  logic       r_ovf;

  logic [7:0] w_edge;
  logic [7:0] w_clr;
  logic [7:0] w_hit;
  logic [7:0] w_pending_next;
  logic [2:0] w_sel;
  logic       w_any;
  logic       w_ack_take;
  logic       w_grant_load;

  assign w_any        = |r_pending;
  assign w_ack_take   = (r_state == S_GRANT) && bus.ack;
  assign w_grant_load = (r_state == S_IDLE) && !bus.ei_n && w_any;

  // Per-bit request bookkeeping.
  // r_block marks lines that were low during reset; such a line must be
  // seen high before a fall counts, even though r_req_q is forced to 1.
  // When an edge and an ack-clear hit the same bit, the set wins and the
  // edge is not an overflow.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign w_edge[gi]         = r_req_q[gi] & ~bus.req_n[gi] & ~r_block[gi];
      assign w_clr[gi]          = w_ack_take & (r_code == 3'(gi));
      assign w_pending_next[gi] = (r_pending[gi] & ~w_clr[gi]) | w_edge[gi];
      assign w_hit[gi]          = w_edge[gi] & r_pending[gi] & ~w_clr[gi];
    end
  endgenerate

`ifdef RR_PRIORITY_EN
  // Rotating priority: after serving s, the search order is s-1, s-2, ...
  // wrapping through 7 and ending at s itself.
  logic [2:0] r_ptr;

  always_comb begin
    logic [2:0] idx;
    w_sel = r_ptr;
    idx   = r_ptr;
    // Walk the order from last to first so the earliest hit overrides.
    for (int k = 8; k >= 1; k--) begin
      idx = r_ptr - 3'(k);
      if (r_pending[idx]) begin
        w_sel = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 3'd0;
    end else if (w_grant_load) begin
      r_ptr <= w_sel;
    end
  end
`else
  // Fixed priority: highest pending index wins.
  always_comb begin
    w_sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_pending[i]) begin
        w_sel = 3'(i);
      end
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic. GRANT ignores ei_n and new edges; only ack leaves.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_load) w_state_next = S_GRANT;
      S_GRANT: if (bus.ack)      w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs and status flags.
  always_comb begin
    bus.valid = (r_state == S_GRANT);
    bus.code  = r_code;
    bus.ovf   = r_ovf;
    bus.gs_n  = ~(~bus.ei_n & w_any);
    bus.eo_n  = ~(~bus.ei_n & ~w_any);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_q   <= 8'hFF;
      r_block   <= ~bus.req_n;
      r_pending <= 8'h00;
      r_code    <= 3'd0;
      r_ovf     <= 1'b0;
    end else begin
      r_req_q   <= bus.req_n;
      r_block   <= r_block & ~bus.req_n;
      r_pending <= w_pending_next;
      r_ovf     <= r_ovf | (|w_hit);
      if (w_grant_load) begin
        r_code <= w_sel;
      end
    end
  end

endmodule
